// File: rtl/tb_pkg.sv
// ---------------------------------------------------------------------------
// tb_pkg
// Shared definitions for the temp-buffer (TB) port controllers of the
// EKF-SLAM systolic datapath.
//   - DIR_* codes: these drive the C-to-TB lane mapper's select input.
//     DIR_IDLE makes the mapper register zeros.
//   - wb_state_t: state encoding of the write-back sequencer.
//   - dirValid(): true only for the directions the write-back path accepts.
// ---------------------------------------------------------------------------
package tb_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } wb_state_t;

  // Write-back only understands walking up (POS) or down (NEG) through rows.
  // IDLE and NEW are rejected at command time.
  function automatic logic dirValid(input logic [1:0] dir);
    return (dir == DIR_POS) || (dir == DIR_NEG);
  endfunction

endpackage

// File: rtl/tb_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_addr_gen
// Holds the row-address and remaining-row counters for one write-back
// command.
// Ports:
//   clk, sys_rst : clock and asynchronous active-high reset
//   i_load       : capture i_base / i_rows (command accepted)
//   i_base       : first TB row address
//   i_rows       : number of rows in the command
//   i_step       : advance both counters by one beat
//   i_down       : 1 = address steps down (NEG), 0 = steps up (POS)
//   o_addr       : row address of the beat currently being accepted
//   o_last       : current beat is the final row (remaining == 1)
// ---------------------------------------------------------------------------
module tb_addr_gen #(
  parameter int TB_AW = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             i_load,
  input  logic [TB_AW-1:0] i_base,
  input  logic [CNT_W-1:0] i_rows,
  input  logic             i_step,
  input  logic             i_down,
  output logic [TB_AW-1:0] o_addr,
  output logic             o_last
);

  logic [TB_AW-1:0] r_addr;
  logic [CNT_W-1:0] r_rem;

  // Load takes priority over step. Address arithmetic wraps naturally
  // modulo 2^TB_AW, so stepping down from row 0 lands on the top row.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_rem  <= i_rows;
    end else if (i_step) begin
      r_addr <= i_down ? (r_addr - TB_AW'(1)) : (r_addr + TB_AW'(1));
      r_rem  <= r_rem - CNT_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == CNT_W'(1));

endmodule

// File: rtl/tb_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_ctrl
// Write-back sequencer for the TB port-B path. It accepts C rows from the
// systolic array. For each accepted row it tells the registered lane mapper
// which direction to use. One cycle later it issues the matching port-B
// write, at the moment the mapper's registered data is valid.
// Ports:
//   clk, sys_rst        : clock and asynchronous active-high reset
//   wb_start            : command pulse, only looked at in IDLE
//   wb_dir              : direction (POS / NEG valid; IDLE / NEW rejected)
//   wb_base_addr        : first TB row of the command
//   wb_rows             : number of rows to write
//   C_valid / C_ready   : C-row handshake; a beat is valid && ready
//   TB_dinb_sel         : mapper select, sampled with C_TB_dinb
//   TB_enb / TB_web     : per-bank port-B enable / write enable
//   TB_addrb            : port-B row address
//   wb_busy             : command in progress (BUSY or DRAIN)
//   wb_done             : one-cycle completion pulse
//   wb_err              : one-cycle rejected-command pulse
// ---------------------------------------------------------------------------
module tb_wb_ctrl
  import tb_pkg::*;
#(
  parameter int X     = 4,
  parameter int L     = 4,
  parameter int TB_AW = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             wb_start,
  input  logic [1:0]       wb_dir,
  input  logic [TB_AW-1:0] wb_base_addr,
  input  logic [CNT_W-1:0] wb_rows,
  input  logic             C_valid,
  output logic             C_ready,
  output logic [1:0]       TB_dinb_sel,
  output logic [L-1:0]     TB_enb,
  output logic [L-1:0]     TB_web,
  output logic [TB_AW-1:0] TB_addrb,
  output logic             wb_busy,
  output logic             wb_done,
  output logic             wb_err
);

  // Only the low X banks receive C lanes. The upper banks are never written.
  localparam logic [L-1:0] LANE_MASK = L'((64'd1 << X) - 64'd1);

  wb_state_t        r_state;
  wb_state_t        w_nextState;
  logic [1:0]       r_dir;
  logic [L-1:0]     r_enb;
  logic [L-1:0]     r_web;
  logic [TB_AW-1:0] r_addrb;
  logic             r_err;

  logic             w_load;
  logic             w_accept;
  logic             w_cmdBad;
  logic [TB_AW-1:0] w_addr;
  logic             w_last;

  assign C_ready  = (r_state == ST_BUSY);
  assign w_accept = C_valid && C_ready;
  assign w_cmdBad = (r_state == ST_IDLE) && wb_start && !dirValid(wb_dir);

  // The mapper sees the direction only on an accepted beat. On every other
  // cycle it registers zeros, so stale data never reaches a TB bank.
  assign TB_dinb_sel = w_accept ? r_dir : DIR_IDLE;

  tb_addr_gen #(
    .TB_AW(TB_AW),
    .CNT_W(CNT_W)
  ) u_addr_gen (
    .clk    (clk),
    .sys_rst(sys_rst),
    .i_load (w_load),
    .i_base (wb_base_addr),
    .i_rows (wb_rows),
    .i_step (w_accept),
    .i_down (r_dir == DIR_NEG),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  // State register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Commands are examined only in IDLE, so a start that
  // arrives in BUSY, DRAIN or DONE is ignored.
  // A zero-row command skips straight to DONE, which produces the completion
  // pulse without any write.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wb_start && dirValid(wb_dir)) begin
          if (wb_rows == '0) begin
            w_nextState = ST_DONE;
          end else begin
            w_load      = 1'b1;
            w_nextState = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (w_accept && w_last) begin
          w_nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: w_nextState = ST_IDLE;
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Direction register, captured with the command.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_dir <= DIR_IDLE;
    end else if (w_load) begin
      r_dir <= wb_dir;
    end
  end

  // Port-B write registers. They trail the accepted beat by exactly one
  // cycle, which lines them up with the mapper's registered output.
  // The address holds between writes so the bus stays quiet.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_enb   <= '0;
      r_web   <= '0;
      r_addrb <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_cmdBad;
      if (w_accept) begin
        r_enb   <= LANE_MASK;
        r_web   <= LANE_MASK;
        r_addrb <= w_addr;
      end else begin
        r_enb <= '0;
        r_web <= '0;
      end
    end
  end

  assign TB_enb   = r_enb;
  assign TB_web   = r_web;
  assign TB_addrb = r_addrb;
  assign wb_err   = r_err;

  // DRAIN is the cycle in which the last write is on the port. Completion is
  // flagged alongside it, and also in the zero-row DONE cycle.
  assign wb_busy = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
  assign wb_done = (r_state == ST_DRAIN) || (r_state == ST_DONE);

endmodule

// File: doc/tb_wb_ctrl.md
Name: tb_wb_ctrl

Overview:
- Write-back sequencer for the temp-buffer (TB) port-B path of the EKF-SLAM systolic datapath.
- Takes a write-back command: direction, base row address and row count.
- Drives TB_dinb_sel to the registered C-to-TB lane mapper once per accepted C row.
- Generates the TB port-B write enables and row addresses aligned to the mapper's one-cycle register delay, and reports busy/done/error.

Parameters:
- X, 4: systolic array C-output lanes (X <= L).
- L, 4: TB banks (lanes of TB_dinb).
- TB_AW, 10: TB row address width.
- CNT_W, 8: row-count width.

Ports:
- clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- wb_start  in  1  command pulse; sampled only in IDLE.
- wb_dir  in  2  direction code: 00 IDLE, 01 POS, 10 NEG, 11 NEW.
- wb_base_addr  in  TB_AW  first TB row to write.
- wb_rows  in  CNT_W  number of rows to write.
- C_valid  in  1  C row present on the C_TB_dinb bus this cycle.
- C_ready  out  1  controller accepts a C row this cycle.
- TB_dinb_sel  out  2  to mapper; sampled together with C_TB_dinb.
- TB_enb  out  L  per-bank port-B enable.
- TB_web  out  L  per-bank port-B write enable.
- TB_addrb  out  TB_AW  port-B row address.
- wb_busy  out  1  command in progress.
- wb_done  out  1  one-cycle completion pulse.
- wb_err  out  1  one-cycle pulse: command rejected.

Behaviour:
- Shared constants: DIR_IDLE=00, DIR_POS=01, DIR_NEG=10, DIR_NEW=11.
- Reset (asynchronous, sys_rst=1):
  - state=IDLE; all registers cleared.
  - TB_enb=0, TB_web=0, TB_addrb=0, wb_busy=0, wb_done=0, wb_err=0.
  - TB_dinb_sel=DIR_IDLE, C_ready=0.
- Reset mid-command aborts immediately. No further writes are issued; an in-flight write enable is dropped.
- States: IDLE, BUSY, DRAIN, DONE.
- IDLE + wb_start:
  - wb_dir is DIR_IDLE or DIR_NEW: wb_err=1 next cycle, stay IDLE, no writes.
  - wb_rows=0: go to DONE; no writes, no err.
  - Otherwise: latch dir_q, addr_q=wb_base_addr, rem_q=wb_rows; go to BUSY.
- BUSY:
  - C_ready=1 while in BUSY.
  - Beat accepted when C_valid && C_ready.
  - TB_dinb_sel is combinational: dir_q on an accepted beat, else DIR_IDLE. This lets the mapper register zeros on idle cycles.
- Write timing (registered): the cycle after an accepted beat,
  - TB_enb=TB_web= low X bits set, upper L-X bits 0;
  - TB_addrb = row address of that beat.
  - Data then matches the mapper output TB_dinb. Latency is exactly 1 cycle from accept to write.
- Address step per accepted beat: POS addr_q+1, NEG addr_q-1.
  - Wraps modulo 2^TB_AW with no error; 0 - 1 gives all ones.
- rem_q decrements per accepted beat. The beat accepted with rem_q=1 moves BUSY to DRAIN.
- DRAIN:
  - C_ready=0.
  - The last write appears this cycle, and wb_done=1 in the same cycle.
  - Then go to IDLE.
- DONE (zero-row path only): wb_done=1 for one cycle, then IDLE.
- wb_busy=1 in BUSY and DRAIN.
- wb_start outside IDLE is ignored, including in the DRAIN cycle.
- C_valid gaps stall the sequence with no write and no address change. There is no timeout.
- wb_start and the done pulse in the same cycle: start is ignored; the new command must be issued after returning to IDLE.
- Idle cycles: TB_web=0 and TB_enb=0; TB_addrb holds its last value.

Decomposition:
- Package tb_pkg: DIR_* localparams and state encodings; shared with the mapper and other TB port controllers.
- One natural sub-module, tb_addr_gen: addr_q/rem_q counters with load, step, up/down and last flag. The FSM and output registers stay in tb_wb_ctrl.
- The mapper is instantiated alongside at integration level, not inside this block.

Test Plan:
- POS, base=0x010, rows=3, C_valid held high:
  - sel=01 for 3 cycles;
  - writes at 0x010, 0x011, 0x012 on the following 3 cycles, TB_web=4'b1111;
  - wb_done coincides with the 0x012 write.
- NEG, base=0x001, rows=3, C_valid pattern 1,0,1,1:
  - writes at 0x001, 0x000, 0x3FF; no write, sel=00 in the gap cycle;
  - done on the 0x3FF write.
- wb_rows=0, and separately wb_dir=11: no TB_web activity ever.
  - Rows=0 gives wb_done at start+1 with wb_err=0.
  - Dir=11 gives wb_err at start+1 with wb_done=0.
- wb_start pulsed during BUSY with different base: ignored; addresses continue from the original command.
- sys_rst asserted asynchronously after 2 of 5 rows (mid-clock):
  - all outputs 0 immediately; no 3rd write;
  - a new POS command after release writes from its own base.
- X=2, L=4 build: TB_web=4'b0011 on every write.
